// File: rtl/alu_8_bit_arbiter.sv
// alu_8_bit_arbiter: two-port round-robin front end for the shared 8-bit ALU.
// Accepts one operation at a time, holds operands steady for the ALU, samples
// the result LAT cycles later and returns it on a tagged response channel.
module alu_8_bit_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_sel,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_sel,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_L = 4'(LAT);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       gnt;
  logic       accept;
  logic [3:0] cnt;

  // Grant selection and next-state; readies are only ever raised in IDLE.
  always_comb begin
    state_nxt  = state;
    gnt        = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        accept = req0_valid | req1_valid;
        // Under contention the requester that did not win last time goes next.
        if (req0_valid && req1_valid) gnt = ~last_grant;
        else                          gnt = req1_valid;
        req0_ready = accept & ~gnt;
        req1_ready = accept &  gnt;
        if (accept) state_nxt = EXEC;
      end
      EXEC: if (cnt == 4'd1) state_nxt = RESP;
      RESP: if (rsp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy is registered alongside so it tracks state exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Datapath: operand capture at accept, latency countdown, result capture,
  // response handshake and completion count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 8'h00;
      op_count   <= 16'h0000;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
    end else begin
      if (accept) begin
        alu_a      <= gnt ? req1_a   : req0_a;
        alu_b      <= gnt ? req1_b   : req0_b;
        alu_sel    <= gnt ? req1_sel : req0_sel;
        rsp_id     <= gnt;
        last_grant <= gnt;
        cnt        <= LAT_L;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          rsp_data  <= alu_op;
          rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_8_bit_arbiter.sv
// Directed bench for alu_8_bit_arbiter: one LAT=1 instance fed by a small ALU
// model, and one LAT=4 instance whose ALU result is driven directly.
module tb_alu_8_bit_arbiter;

  localparam logic [2:0] XOR = 3'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [2:0]  req0_sel, req1_sel;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [7:0]  alu_a, alu_b, alu_op, rsp_data;
  logic [2:0]  alu_sel;
  logic [15:0] op_count;

  logic        r4_0, r4_1, v4, id4, busy4;
  logic [7:0]  a4, b4, d4, alu_op4;
  logic [2:0]  s4;
  logic [15:0] cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference ALU for the LAT=1 instance.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_op = alu_a + alu_b;
      3'd1:    alu_op = alu_a - alu_b;
      3'd2:    alu_op = alu_a ^ alu_b;
      3'd3:    alu_op = alu_a & alu_b;
      default: alu_op = alu_a | alu_b;
    endcase
  end

  alu_8_bit_arbiter #(.LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_op(alu_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
  );

  alu_8_bit_arbiter #(.LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(r4_0), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r4_1), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(a4), .alu_b(b4), .alu_sel(s4), .alu_op(alu_op4),
    .rsp_valid(v4), .rsp_ready(rsp_ready), .rsp_id(id4),
    .rsp_data(d4), .busy(busy4), .op_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    alu_op4    = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; returns the granted requester or -1 on timeout.
  task automatic wait_ready(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready) begin who = 0; break; end
      if (req1_ready) begin who = 1; break; end
      tick();
    end
  endtask

  // One full operation with rsp_ready high: grant, result two cycles later, back to IDLE.
  task automatic run_op(input int exp_id, input logic [7:0] exp_data);
    int who;
    wait_ready(who);
    chk("grant", who, exp_id);
    tick();
    tick();
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_data", rsp_data, exp_data);
    tick();
  endtask

  initial begin
    int who;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1; alu_op4 = 8'h00;
    req0_sel = XOR; req0_a = 8'h01; req0_b = 8'h16;
    req1_sel = XOR; req1_a = 8'h07; req1_b = 8'h0A;

    // Reset state
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);

    // Single request
    req0_valid = 1'b1;
    #1;
    chk("single_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("single_ready_pulse", req0_ready, 0);
    chk("single_busy", busy, 1);
    chk("single_alu_a", alu_a, 8'h01);
    chk("single_alu_b", alu_b, 8'h16);
    chk("single_early_valid", rsp_valid, 0);
    tick(); #1;
    chk("single_valid", rsp_valid, 1);
    chk("single_data", rsp_data, 8'h17);
    chk("single_id", rsp_id, 0);
    tick(); #1;
    chk("single_count", op_count, 1);
    chk("single_idle", busy, 0);
    chk("single_alu_hold", alu_a, 8'h01);

    // Contention: grants alternate starting with requester 0
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    run_op(0, 8'h17);
    run_op(1, 8'h0D);
    run_op(0, 8'h17);
    run_op(1, 8'h0D);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("cont_count", op_count, 4);

    // Backpressure: 5 stall cycles in RESP
    do_reset();
    rsp_ready  = 1'b0;
    req1_valid = 1'b1;
    wait_ready(who);
    chk("bp_grant", who, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_data", rsp_data, 8'h0D);
      chk("bp_no_ready", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_still_valid", rsp_valid, 1);
    tick(); #1;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_ready", req0_ready, 1);
    chk("bp_count", op_count, 1);
    req0_valid = 1'b0;

    // Latency LAT=4: only the value present in cycle T+4 is captured
    do_reset();
    req0_valid = 1'b1;
    #1;
    chk("lat_ready", r4_0, 1);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      alu_op4 = 8'hEE;
      #1;
      chk("lat_early_valid", v4, 0);
      tick();
    end
    alu_op4 = 8'h5A;
    #1;
    chk("lat_t4_valid", v4, 0);
    chk("lat_alu_a", a4, 8'h01);
    tick();
    alu_op4 = 8'hEE;
    #1;
    chk("lat_valid", v4, 1);
    chk("lat_data", d4, 8'h5A);
    tick(); #1;
    chk("lat_count", cnt4, 1);

    // Reset mid-operation
    do_reset();
    req0_valid = 1'b1;
    wait_ready(who);
    chk("mid_grant", who, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(); #1;
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_count", op_count, 0);
    req1_valid = 1'b1;
    run_op(1, 8'h0D);
    req0_valid = 1'b1;
    run_op(0, 8'h17);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Counter wrap from a preloaded value
    do_reset();
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    #1;
    chk("wrap_preload", op_count, 16'hFFFE);
    req0_valid = 1'b1;
    run_op(0, 8'h17);
    #1;
    chk("wrap_ffff", op_count, 16'hFFFF);
    run_op(0, 8'h17);
    #1;
    chk("wrap_zero", op_count, 16'h0000);
    req0_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
